// File: rtl/rca_config_loader.sv
// rca_config_loader: accepts one RCA configuration command per handshake and
// walks every source port, then every destination port, one port per cycle,
// strobing the config register file for each port whose mask bit is set.
// While busy it owns the shared rca_sel so the walk targets the latched RCA.
module rca_config_loader #(
   parameter  int NUM_RCAS        = 4,
   parameter  int NUM_READ_PORTS  = 3,
   parameter  int NUM_WRITE_PORTS = 2,
   localparam int RCA_W  = (NUM_RCAS > 1)       ? $clog2(NUM_RCAS)       : 1,
   localparam int PORT_W = (NUM_READ_PORTS > 1) ? $clog2(NUM_READ_PORTS) : 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   input  logic [RCA_W-1:0]             cmd_rca,
   input  logic [5*NUM_READ_PORTS-1:0]  cmd_src_addrs,
   input  logic [5*NUM_WRITE_PORTS-1:0] cmd_dest_addrs,
   input  logic [NUM_READ_PORTS-1:0]    cmd_src_mask,
   input  logic [NUM_WRITE_PORTS-1:0]   cmd_dest_mask,
   input  logic                         abort,
   input  logic [RCA_W-1:0]             issue_rca_sel,
   output logic [RCA_W-1:0]             rca_sel,
   output logic                         wr_en,
   output logic [PORT_W-1:0]            w_port_sel,
   output logic                         w_src_dest_port,
   output logic [4:0]                   w_reg_addr,
   output logic                         busy,
   output logic                         done
);

   // The dest walk reuses the src port counter, so it can never be wider.
   if (NUM_WRITE_PORTS > NUM_READ_PORTS) begin : g_bad_ports
      $error("rca_config_loader: NUM_WRITE_PORTS must not exceed NUM_READ_PORTS");
   end

   typedef enum logic [1:0] {S_IDLE, S_SRC, S_DEST, S_DONE} state_t;

   localparam logic [PORT_W-1:0] LAST_SRC  = PORT_W'(NUM_READ_PORTS - 1);
   localparam logic [PORT_W-1:0] LAST_DEST = PORT_W'(NUM_WRITE_PORTS - 1);

   state_t                                r_state;
   logic [PORT_W-1:0]                     r_idx;
   logic [RCA_W-1:0]                      r_rca;
   logic [NUM_READ_PORTS-1:0][4:0]        r_src;
   logic [NUM_WRITE_PORTS-1:0][4:0]       r_dest;
   logic [NUM_READ_PORTS-1:0]             r_src_mask;
   logic [NUM_WRITE_PORTS-1:0]            r_dest_mask;

   logic                                  w_src_en;
   logic [4:0]                            w_src_addr;
   logic                                  w_dest_en;
   logic [4:0]                            w_dest_addr;

   // Sequencer: latch the command at accept, then step idx through src then dest ports.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_rca       <= '0;
         r_src       <= '0;
         r_dest      <= '0;
         r_src_mask  <= '0;
         r_dest_mask <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (cmd_valid) begin
                  r_rca       <= cmd_rca;
                  r_src       <= cmd_src_addrs;
                  r_dest      <= cmd_dest_addrs;
                  r_src_mask  <= cmd_src_mask;
                  r_dest_mask <= cmd_dest_mask;
                  r_idx       <= '0;
                  r_state     <= S_SRC;
               end
            end
            S_SRC: begin
               if (abort) begin
                  r_idx   <= '0;
                  r_state <= S_IDLE;
               end else if (r_idx == LAST_SRC) begin
                  r_idx   <= '0;
                  r_state <= S_DEST;
               end else begin
                  r_idx   <= r_idx + 1'b1;
               end
            end
            S_DEST: begin
               if (abort) begin
                  r_idx   <= '0;
                  r_state <= S_IDLE;
               end else if (r_idx == LAST_DEST) begin
                  r_idx   <= '0;
                  r_state <= S_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Select the latched address/mask for the current port from each table.
   always_comb begin
      w_src_en    = 1'b0;
      w_src_addr  = '0;
      w_dest_en   = 1'b0;
      w_dest_addr = '0;
      for (int i = 0; i < NUM_READ_PORTS; i++) begin
         if (r_idx == PORT_W'(i)) begin
            w_src_en   = r_src_mask[i];
            w_src_addr = r_src[i];
         end
      end
      for (int j = 0; j < NUM_WRITE_PORTS; j++) begin
         if (r_idx == PORT_W'(j)) begin
            w_dest_en   = r_dest_mask[j];
            w_dest_addr = r_dest[j];
         end
      end
   end

   // Outputs decode from flops only, so an async reset drops wr_en at once.
   always_comb begin
      cmd_ready       = (r_state == S_IDLE);
      busy            = (r_state != S_IDLE);
      done            = (r_state == S_DONE);
      rca_sel         = busy ? r_rca : issue_rca_sel;
      w_port_sel      = r_idx;
      w_src_dest_port = (r_state == S_DEST);
      wr_en           = 1'b0;
      w_reg_addr      = '0;
      if (r_state == S_SRC) begin
         wr_en      = w_src_en;
         w_reg_addr = w_src_addr;
      end else if (r_state == S_DEST) begin
         wr_en      = w_dest_en;
         w_reg_addr = w_dest_addr;
      end
   end

endmodule

// File: tb/tb_rca_config_loader.sv
// Scoreboard bench for rca_config_loader: stimulus pushes expected writes and
// done pulses (tagged with the cycle they must appear in); a negedge monitor
// pops and compares whenever the DUT strobes wr_en or done.
module tb_rca_config_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [1:0] cmd_rca = '0;
   logic [14:0] cmd_src_addrs = '0;
   logic [9:0] cmd_dest_addrs = '0;
   logic [2:0] cmd_src_mask = '0;
   logic [1:0] cmd_dest_mask = '0;
   logic       abort = 1'b0;
   logic [1:0] issue_rca_sel = 2'd2;
   logic [1:0] rca_sel;
   logic       wr_en;
   logic [1:0] w_port_sel;
   logic       w_src_dest_port;
   logic [4:0] w_reg_addr;
   logic       busy;
   logic       done;

   rca_config_loader dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_rca(cmd_rca), .cmd_src_addrs(cmd_src_addrs), .cmd_dest_addrs(cmd_dest_addrs),
      .cmd_src_mask(cmd_src_mask), .cmd_dest_mask(cmd_dest_mask), .abort(abort),
      .issue_rca_sel(issue_rca_sel), .rca_sel(rca_sel), .wr_en(wr_en),
      .w_port_sel(w_port_sel), .w_src_dest_port(w_src_dest_port),
      .w_reg_addr(w_reg_addr), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         c;
      logic       sd;
      logic [1:0] port;
      logic [4:0] addr;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done[$];
   int  total = 0;
   int  passed = 0;

   // Register-file model written from the DUT strobes, used for readback.
   logic [4:0] rf_src [4][3];
   logic [4:0] rf_dst [4][2];
   always @(posedge clk) begin
      if (rst_n && wr_en) begin
         if (w_src_dest_port) rf_dst[rca_sel][w_port_sel[0]] <= w_reg_addr;
         else                 rf_src[rca_sel][w_port_sel]    <= w_reg_addr;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compare every strobe against the head of the expectation queues.
   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         if (exp_wr.size() == 0) chk("unexpected_wr_en", 1, 0);
         else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_cycle", cyc, e.c);
            chk("wr_src_dest", int'(w_src_dest_port), int'(e.sd));
            chk("wr_port", int'(w_port_sel), int'(e.port));
            chk("wr_addr", int'(w_reg_addr), int'(e.addr));
         end
      end
      if (rst_n && done) begin
         if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
         else chk("done_cycle", cyc, exp_done.pop_front());
      end
   end

   // Expected strobes for a command accepted at edge A; spec cycle k is cyc A+k-1.
   // Only strobes up to spec cycle 'last' are expected (abort/reset truncation).
   task automatic push_exp(input int A, input logic [4:0] s[3], input logic [4:0] d[2],
                           input logic [2:0] sm, input logic [1:0] dm, input int last);
      for (int i = 0; i < 3; i++)
         if (sm[i] && (1 + i) <= last) exp_wr.push_back('{A + i, 1'b0, 2'(i), s[i]});
      for (int j = 0; j < 2; j++)
         if (dm[j] && (4 + j) <= last) exp_wr.push_back('{A + 3 + j, 1'b1, 2'(j), d[j]});
      if (last >= 6) exp_done.push_back(A + 5);
   endtask

   task automatic drive(input logic [1:0] rca, input logic [4:0] s[3], input logic [4:0] d[2],
                        input logic [2:0] sm, input logic [1:0] dm);
      cmd_rca        = rca;
      cmd_src_addrs  = {s[2], s[1], s[0]};
      cmd_dest_addrs = {d[1], d[0]};
      cmd_src_mask   = sm;
      cmd_dest_mask  = dm;
   endtask

   // Issue one command from idle; returns A = cyc value right after the accept edge.
   task automatic send(input logic [1:0] rca, input logic [4:0] s[3], input logic [4:0] d[2],
                       input logic [2:0] sm, input logic [1:0] dm, input int last, output int A);
      int n;
      n = 0;
      @(negedge clk);
      while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
      chk("ready_before_send", int'(cmd_ready), 1);
      drive(rca, s, d, sm, dm);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      A = cyc;
      cmd_valid = 1'b0;
      push_exp(A, s, d, sm, dm, last);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!cmd_ready && n < 20) begin @(posedge clk); #1; n++; end
      chk("returns_idle", int'(cmd_ready), 1);
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_wr_en"}, int'(wr_en), 0);
      chk({tag, "_port_sel"}, int'(w_port_sel), 0);
      chk({tag, "_src_dest"}, int'(w_src_dest_port), 0);
      chk({tag, "_reg_addr"}, int'(w_reg_addr), 0);
      chk({tag, "_rca_sel"}, int'(rca_sel), int'(issue_rca_sel));
   endtask

   initial begin
      int A;
      logic [4:0] s[3];
      logic [4:0] d[2];

      // Reset: held low across several edges, then released.
      repeat (3) @(posedge clk);
      #1 chk_idle_outputs("in_reset");
      chk("in_reset_rca_sel_2", int'(rca_sel), 2);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1 chk_idle_outputs("after_reset");

      // Full command: rca 3, src {7,9,31}, dest {1,2}, all masks set.
      s = '{5'd7, 5'd9, 5'd31}; d = '{5'd1, 5'd2};
      send(2'd3, s, d, 3'b111, 2'b11, 6, A);
      chk("full_busy_c1", int'(busy), 1);
      chk("full_rca_sel_c1", int'(rca_sel), 3);
      wait_idle();
      chk("full_idle_cycle", cyc, A + 6);
      chk("rb_src0", int'(rf_src[3][0]), 7);
      chk("rb_src1", int'(rf_src[3][1]), 9);
      chk("rb_src2", int'(rf_src[3][2]), 31);
      chk("rb_dst0", int'(rf_dst[3][0]), 1);
      chk("rb_dst1", int'(rf_dst[3][1]), 2);

      // Partial masks: only src port 1 (cycle 2) and dest port 0 (cycle 4).
      s = '{5'd4, 5'd5, 5'd6}; d = '{5'd10, 5'd11};
      send(2'd1, s, d, 3'b010, 2'b01, 6, A);
      wait_idle();

      // All-zero masks: no strobes, done still in cycle 6.
      s = '{5'd12, 5'd13, 5'd14}; d = '{5'd15, 5'd16};
      send(2'd0, s, d, 3'b000, 2'b00, 6, A);
      wait_idle();

      // Back-to-back with cmd_valid held: second accepted at edge 7.
      issue_rca_sel = 2'd0;
      @(negedge clk);
      s = '{5'd20, 5'd21, 5'd22}; d = '{5'd23, 5'd24};
      drive(2'd1, s, d, 3'b111, 2'b11);
      cmd_valid = 1'b1;
      @(posedge clk); #1;
      A = cyc;
      push_exp(A, s, d, 3'b111, 2'b11, 6);
      s = '{5'd25, 5'd26, 5'd27}; d = '{5'd28, 5'd29};
      drive(2'd2, s, d, 3'b101, 2'b10);
      push_exp(A + 7, s, d, 3'b101, 2'b10, 6);
      for (int k = 0; k < 6; k++) begin
         chk("b2b_ready_low", int'(cmd_ready), 0);
         @(posedge clk); #1;
      end
      chk("b2b_ready_c7", int'(cmd_ready), 1);
      chk("b2b_rca_sel_c7", int'(rca_sel), 0);
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      chk("b2b_rca_sel_c8", int'(rca_sel), 2);
      chk("b2b_busy_c8", int'(busy), 1);
      wait_idle();

      // Abort in cycle 2: strobes in cycles 1 and 2 only, no done.
      s = '{5'd3, 5'd6, 5'd9}; d = '{5'd17, 5'd18};
      send(2'd2, s, d, 3'b111, 2'b11, 2, A);
      @(posedge clk); #1 abort = 1'b1;
      @(posedge clk); #1 abort = 1'b0;
      chk("abort_busy_c3", int'(busy), 0);
      chk("abort_ready_c3", int'(cmd_ready), 1);
      repeat (6) @(posedge clk);

      // Async reset in cycle 4: wr_en drops before the next edge, no done.
      s = '{5'd8, 5'd19, 5'd30}; d = '{5'd5, 5'd6};
      send(2'd1, s, d, 3'b111, 2'b11, 3, A);
      repeat (3) @(posedge clk);
      #2;
      chk("rst_pre_wr_en_c4", int'(wr_en), 1);
      rst_n = 1'b0;
      #1;
      chk("rst_async_wr_en", int'(wr_en), 0);
      chk("rst_async_busy", int'(busy), 0);
      chk("rst_async_ready", int'(cmd_ready), 1);
      @(negedge clk) rst_n = 1'b1;
      repeat (8) @(posedge clk);

      #1;
      chk("exp_wr_drained", exp_wr.size(), 0);
      chk("exp_done_drained", exp_done.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
      $fatal(1);
   end

endmodule
